// File: rtl/sr04_echo_emulator.sv
// sr04_echo_emulator: HC-SR04 trigger/echo responder for hardware-in-the-loop.
// Watches the trigger, checks its minimum width, waits the burst delay, then
// drives an echo pulse whose width is distance * US_PER_CM microseconds.
// Optional macro SR04_JITTER_EN adds 0-7 us LFSR jitter to the echo width.
module sr04_echo_emulator #(
   parameter int CLK_FREQ      = 100_000_000,
   parameter int DIST_W        = 9,
   parameter int MIN_TRIG_US   = 10,
   parameter int ECHO_DELAY_US = 500,
   parameter int US_PER_CM     = 58,
   parameter int MAX_DIST_CM   = 400,
   parameter int NO_OBJ_US     = 38000,
   parameter int HOLDOFF_US    = 10000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_trigger,
   input  logic [DIST_W-1:0] i_distance,
   output logic              o_echo,
   output logic              o_busy,
   output logic              o_trig_err
);

   localparam int DIV = (CLK_FREQ / 1_000_000 < 1) ? 1 : CLK_FREQ / 1_000_000;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

   localparam logic [15:0] MIN_T  = 16'(MIN_TRIG_US);
   localparam logic [15:0] DLY_T  = 16'(ECHO_DELAY_US - 1);
   localparam logic [15:0] HOLD_T = 16'(HOLDOFF_US - 1);
   localparam logic [15:0] UPC    = 16'(US_PER_CM);
   localparam logic [15:0] MAXD   = 16'(MAX_DIST_CM);
   localparam logic [15:0] NOOBJ  = 16'(NO_OBJ_US);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_BURST,
      S_ECHO,
      S_HOLD
   } state_t;

   state_t        state, state_n;
   logic [PW-1:0] presc;
   logic          tick;
   logic [15:0]   cnt, cnt_n;
   logic [15:0]   echo_len, echo_len_n;
   logic          echo_n, busy_n, err_n;
   logic          trig_s1, trig_s2, trig_s3;
   logic          trig_rise, trig_fall;
   logic          accept;
   logic [15:0]   dist_w;
   logic [15:0]   base_len, latch_len;

   // Free-running 1 us prescaler; never re-phased by the trigger.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) presc <= '0;
      else        presc <= tick ? '0 : presc + 1'b1;
   end

   assign tick = (presc == PRE_MAX);

   // Two-flop synchronizer plus one history flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) {trig_s3, trig_s2, trig_s1} <= 3'b000;
      else        {trig_s3, trig_s2, trig_s1} <= {trig_s2, trig_s1, i_trigger};
   end

   assign trig_rise = trig_s2 & ~trig_s3;
   assign trig_fall = ~trig_s2 & trig_s3;

   // Echo length for the distance present at the accepting trigger fall.
   assign dist_w   = 16'(i_distance);
   assign base_len = (dist_w == 16'd0 || dist_w > MAXD) ? NOOBJ : dist_w * UPC;
   assign accept   = (state == S_TRIG) && trig_fall && (cnt >= MIN_T);

`ifdef SR04_JITTER_EN
   logic [15:0] lfsr;

   // Fibonacci LFSR (taps 16,14,13,11), stepped once per accepted trigger.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      lfsr <= 16'hACE1;
      else if (accept) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign latch_len = base_len + {13'd0, lfsr[2:0]};
`else
   assign latch_len = base_len;
`endif

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         echo_len   <= '0;
         o_echo     <= 1'b0;
         o_busy     <= 1'b0;
         o_trig_err <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         echo_len   <= echo_len_n;
         o_echo     <= echo_n;
         o_busy     <= busy_n;
         o_trig_err <= err_n;
      end
   end

   // Next-state and output decode; trigger edges matter only in IDLE/TRIG,
   // and a fall coincident with a tick is taken before the tick.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      echo_len_n = echo_len;
      echo_n     = o_echo;
      busy_n     = o_busy;
      err_n      = 1'b0;
      case (state)
         S_IDLE: begin
            if (trig_rise) begin
               cnt_n   = '0;
               state_n = S_TRIG;
            end
         end
         S_TRIG: begin
            if (trig_fall) begin
               if (accept) begin
                  echo_len_n = latch_len;
                  cnt_n      = '0;
                  busy_n     = 1'b1;
                  state_n    = S_BURST;
               end else begin
                  err_n   = 1'b1;
                  state_n = S_IDLE;
               end
            end else if (tick && cnt < MIN_T) begin
               cnt_n = cnt + 16'd1;
            end
         end
         S_BURST: begin
            if (tick) begin
               if (cnt == DLY_T) begin
                  cnt_n   = '0;
                  echo_n  = 1'b1;
                  state_n = S_ECHO;
               end else begin
                  cnt_n = cnt + 16'd1;
               end
            end
         end
         S_ECHO: begin
            if (tick) begin
               if (cnt == echo_len - 16'd1) begin
                  cnt_n   = '0;
                  echo_n  = 1'b0;
                  state_n = S_HOLD;
               end else begin
                  cnt_n = cnt + 16'd1;
               end
            end
         end
         S_HOLD: begin
            if (tick) begin
               if (cnt == HOLD_T) begin
                  cnt_n   = '0;
                  busy_n  = 1'b0;
                  state_n = S_IDLE;
               end else begin
                  cnt_n = cnt + 16'd1;
               end
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
            echo_n  = 1'b0;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_sr04_echo_emulator.sv
// tb_sr04_echo_emulator: randomized scenarios against a timing model of the
// echo responder, run with scaled-down timing parameters (2 clk per us).
`timescale 1ns/1ps
module tb_sr04_echo_emulator;

   localparam int CF    = 2_000_000;
   localparam int DIV   = 2;
   localparam int MINT  = 10;
   localparam int DLY   = 20;
   localparam int UPC   = 2;
   localparam int MAXD  = 400;
   localparam int NOOBJ = 1000;
   localparam int HOLD  = 50;
`ifdef SR04_JITTER_EN
   localparam int JIT = 7;
`else
   localparam int JIT = 0;
`endif
   localparam int BUDGET = 4000 * DIV;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_trigger = 1'b0;
   logic [8:0] i_distance = '0;
   logic       o_echo, o_busy, o_trig_err;

   int vec = 0, miss = 0;

   sr04_echo_emulator #(
      .CLK_FREQ(CF), .DIST_W(9), .MIN_TRIG_US(MINT), .ECHO_DELAY_US(DLY),
      .US_PER_CM(UPC), .MAX_DIST_CM(MAXD), .NO_OBJ_US(NOOBJ), .HOLDOFF_US(HOLD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_trigger(i_trigger), .i_distance(i_distance),
      .o_echo(o_echo), .o_busy(o_busy), .o_trig_err(o_trig_err)
   );

   always #5 clk = ~clk;

   // Edge monitor sampled on the falling clock edge.
   int cyc = 0;
   int n_er = 0, n_ef = 0, n_br = 0, n_bf = 0, n_err = 0;
   int t_er = 0, t_ef = 0, t_br = 0, t_bf = 0;
   int err_run = 0, err_max = 0;
   logic pe = 1'b0, pb = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (o_echo && !pe) begin n_er++; t_er = cyc; end
      if (!o_echo && pe) begin n_ef++; t_ef = cyc; end
      if (o_busy && !pb) begin n_br++; t_br = cyc; end
      if (!o_busy && pb) begin n_bf++; t_bf = cyc; end
      if (o_trig_err) begin
         if (err_run == 0) n_err++;
         err_run++;
         if (err_run > err_max) err_max = err_run;
      end else err_run = 0;
      pe = o_echo;
      pb = o_busy;
   end

   int t_fall = 0;

   // Reference: echo width in us from the distance rules.
   function automatic int exp_len(input int d);
      if (d == 0 || d > MAXD) return NOOBJ;
      return d * UPC;
   endfunction

   task automatic fire(input int w_us, input int d);
      @(posedge clk); #2;
      i_distance = 9'(d);
      i_trigger  = 1'b1;
      repeat (w_us * DIV) @(posedge clk);
      #2;
      i_trigger = 1'b0;
      t_fall    = cyc;
   endtask

   task automatic wait_bf(input int start);
      int n = 0;
      while (n_bf == start && n < BUDGET) begin @(posedge clk); n++; end
      if (n_bf == start) begin
         vec++; miss++;
         $display("FAIL busy_fall_timeout: got no busy fall within %0d clk, want one", BUDGET);
      end
   endtask

   task automatic wait_er(input int start);
      int n = 0;
      while (n_er == start && n < BUDGET) begin @(posedge clk); n++; end
      if (n_er == start) begin
         vec++; miss++;
         $display("FAIL echo_rise_timeout: got no echo rise within %0d clk, want one", BUDGET);
      end
   endtask

   // One full accepted measurement, checking pulse count and width.
   task automatic meas(input string nm, input int w_us, input int d);
      int er0, bf0, w, lo, hi;
      er0 = n_er; bf0 = n_bf;
      fire(w_us, d);
      wait_bf(bf0);
      w  = t_ef - t_er;
      lo = exp_len(d) * DIV - DIV;
      hi = (exp_len(d) + JIT) * DIV + DIV;
      vec++;
      if (n_er - er0 !== 1) begin
         miss++; $display("FAIL %s_count d=%0d: got %0d echoes, want 1", nm, d, n_er - er0);
      end
      vec++;
      if (w < lo || w > hi) begin
         miss++; $display("FAIL %s_width d=%0d: got %0d clk, want %0d..%0d", nm, d, w, lo, hi);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (4) @(posedge clk);
      vec++; if (o_echo !== 1'b0)     begin miss++; $display("FAIL reset_echo: got %b want 0", o_echo); end
      vec++; if (o_busy !== 1'b0)     begin miss++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      vec++; if (o_trig_err !== 1'b0) begin miss++; $display("FAIL reset_err: got %b want 0", o_trig_err); end
      @(negedge clk); rst_n = 1'b1;
      repeat (5) @(posedge clk);
   endtask

   task automatic test_basic();
      int err0, d;
      err0 = n_err;
      meas("basic", MINT + 1, 100);
      d = t_br - t_fall;
      vec++; if (d < 1 || d > 5) begin miss++; $display("FAIL basic_busy_rise: got %0d clk after fall, want 1..5", d); end
      d = t_er - t_fall;
      vec++; if (d < DLY * DIV - DIV || d > DLY * DIV + DIV + 4) begin
         miss++; $display("FAIL basic_delay: got %0d clk, want %0d..%0d", d, DLY * DIV - DIV, DLY * DIV + DIV + 4);
      end
      d = t_bf - t_ef;
      vec++; if (d < HOLD * DIV - DIV || d > HOLD * DIV + DIV) begin
         miss++; $display("FAIL basic_holdoff: got %0d clk, want %0d..%0d", d, HOLD * DIV - DIV, HOLD * DIV + DIV);
      end
      vec++; if (n_err !== err0) begin miss++; $display("FAIL basic_no_err: got %0d errs want 0", n_err - err0); end
   endtask

   task automatic test_short_trigger();
      int er0, br0, err0;
      er0 = n_er; br0 = n_br; err0 = n_err; err_max = 0;
      fire(MINT / 2, 100);
      repeat (20) @(posedge clk);
      vec++; if (n_err - err0 !== 1) begin miss++; $display("FAIL short_err_count: got %0d want 1", n_err - err0); end
      vec++; if (err_max !== 1)      begin miss++; $display("FAIL short_err_width: got %0d clk want 1", err_max); end
      vec++; if (n_er !== er0)       begin miss++; $display("FAIL short_no_echo: got %0d echoes want 0", n_er - er0); end
      vec++; if (n_br !== br0)       begin miss++; $display("FAIL short_no_busy: got %0d busy want 0", n_br - br0); end
   endtask

   task automatic test_range();
      int dl[$];
      dl = '{0, 401, 400};
      for (int i = 0; i < 3; i++) dl.push_back(int'($urandom_range(1, MAXD)));
      dl.push_back(int'($urandom_range(MAXD + 1, 511)));
      foreach (dl[i]) meas("range", MINT + int'($urandom_range(1, 4)), dl[i]);
   endtask

   task automatic test_back_to_back();
      int er0, bf0, br0, w, lo, hi, d;
      er0 = n_er; bf0 = n_bf;
      fire(MINT + 2, 100);
      repeat (5 * DIV) @(posedge clk);
      i_distance = 9'd50;
      wait_er(er0);
      repeat (50) @(posedge clk);
      fire(MINT + 2, 77);
      wait_bf(bf0);
      w = t_ef - t_er; lo = 100 * UPC * DIV - DIV; hi = (100 * UPC + JIT) * DIV + DIV;
      vec++; if (n_er - er0 !== 1) begin miss++; $display("FAIL b2b_count: got %0d echoes want 1", n_er - er0); end
      vec++; if (w < lo || w > hi) begin miss++; $display("FAIL b2b_width: got %0d clk want %0d..%0d", w, lo, hi); end
      repeat (10 * DIV) @(posedge clk);
      d = int'($urandom_range(1, 150));
      meas("b2b_after", MINT + 2, d);
      // trigger raised during holdoff and held past IDLE entry must be ignored
      er0 = n_er; bf0 = n_bf;
      fire(MINT + 2, 30);
      while (n_ef == n_er - 1 && o_echo) @(posedge clk);
      repeat (10) @(posedge clk);
      i_trigger = 1'b1;
      wait_bf(bf0);
      br0 = n_br;
      repeat (20 * DIV) @(posedge clk);
      #2 i_trigger = 1'b0;
      repeat (30) @(posedge clk);
      vec++; if (n_br !== br0) begin miss++; $display("FAIL held_trigger: got %0d busy rises want 0", n_br - br0); end
   endtask

   task automatic test_reset_mid_echo();
      int er0;
      er0 = n_er;
      fire(MINT + 2, 100);
      wait_er(er0);
      repeat (20) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      vec++; if (o_echo !== 1'b0) begin miss++; $display("FAIL rst_mid_echo: got %b want 0", o_echo); end
      vec++; if (o_busy !== 1'b0) begin miss++; $display("FAIL rst_mid_busy: got %b want 0", o_busy); end
      #99 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      meas("rst_after", MINT + 2, 20);
   endtask

   task automatic test_jitter();
      int er0, bf0, w, wmin, wmax, base;
      wmin = 1 << 30; wmax = 0; base = 100 * UPC * DIV;
      for (int i = 0; i < 16; i++) begin
         er0 = n_er; bf0 = n_bf;
         fire(MINT + 1, 100);
         wait_bf(bf0);
         w = t_ef - t_er;
         if (w < wmin) wmin = w;
         if (w > wmax) wmax = w;
         vec++;
         if (n_er - er0 !== 1 || w < base - DIV || w > base + JIT * DIV + DIV) begin
            miss++; $display("FAIL jitter_width[%0d]: got %0d clk (%0d echoes), want %0d..%0d",
                             i, w, n_er - er0, base - DIV, base + JIT * DIV + DIV);
         end
      end
`ifdef SR04_JITTER_EN
      vec++; if (wmax == wmin) begin miss++; $display("FAIL jitter_spread: got all widths %0d clk, want variation", wmin); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short_trigger();
      test_range();
      test_back_to_back();
      test_reset_mid_echo();
      test_jitter();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
